// File: rtl/aux_input_conditioner_pkg.sv
// Shared encodings and clock-rate helpers for the board-input conditioner.
package aux_input_conditioner_pkg;

  localparam int unsigned CLK_KHZ = 100_000;

  localparam logic [1:0] RES_IDLE        = 2'd0;
  localparam logic [1:0] RES_PRESS_CHK   = 2'd1;
  localparam logic [1:0] RES_PRESSED     = 2'd2;
  localparam logic [1:0] RES_RELEASE_CHK = 2'd3;

  localparam logic [0:0] SW_IDLE = 1'b0;
  localparam logic [0:0] SW_CHK  = 1'b1;

  // Number of core-clock cycles in the given number of milliseconds.
  function automatic int debounce_cycles(input int ms);
    return int'(CLK_KHZ) * ms;
  endfunction

endpackage

// File: rtl/aux_sync_chain.sv
// Multi-flop synchroniser for a bus of independent asynchronous levels.
module aux_sync_chain #(
  parameter int Width  = 1,
  parameter int Stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] chain_q [Stages];
  logic [Width-1:0] chain_d [Stages];

  always_comb begin
    chain_d[0] = din;
    for (int i = 1; i < Stages; i++) chain_d[i] = chain_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Stages; i++) chain_q[i] <= '0;
    end else begin
      for (int i = 0; i < Stages; i++) chain_q[i] <= chain_d[i];
    end
  end

  assign dout = chain_q[Stages-1];

endmodule

// File: rtl/aux_input_conditioner.sv
// Synchronises and debounces the slide switches and the resume button.
module aux_input_conditioner
  import aux_input_conditioner_pkg::*;
#(
  parameter int SwtWidth    = 16,
  parameter int SyncStages  = 2,
  parameter int DebounceCnt = debounce_cycles(10)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SwtWidth-1:0] swt_raw,
  input  logic                resume_raw,
  output logic [SwtWidth-1:0] swt,
  output logic                swt_changed,
  output logic                resume_held,
  output logic                resume_pulse
);

  localparam int CW = $clog2(DebounceCnt + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DebounceCnt - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SwtWidth-1:0] swt_s;
  logic                res_s;

  aux_sync_chain #(.Width(SwtWidth), .Stages(SyncStages)) u_swt_sync (
    .clk(clk), .rst(rst), .din(swt_raw), .dout(swt_s)
  );

  aux_sync_chain #(.Width(1), .Stages(SyncStages)) u_res_sync (
    .clk(clk), .rst(rst), .din(resume_raw), .dout(res_s)
  );

  logic [0:0]          sw_state_q, sw_state_d;
  logic [SwtWidth-1:0] sw_cand_q, sw_cand_d;
  logic [CW-1:0]       sw_cnt_q, sw_cnt_d;
  logic [SwtWidth-1:0] swt_q, swt_d;
  logic                swt_changed_q, swt_changed_d;

  // Whole bus is one value: any new pattern restarts the stability count.
  always_comb begin
    sw_state_d    = sw_state_q;
    sw_cand_d     = sw_cand_q;
    sw_cnt_d      = sw_cnt_q;
    swt_d         = swt_q;
    swt_changed_d = 1'b0;
    case (sw_state_q)
      SW_IDLE: begin
        if (swt_s != swt_q) begin
          sw_cand_d  = swt_s;
          sw_cnt_d   = '0;
          sw_state_d = SW_CHK;
        end
      end
      default: begin
        if (swt_s == sw_cand_q) begin
          if (sw_cnt_q == CNT_LAST) begin
            swt_d         = sw_cand_q;
            swt_changed_d = 1'b1;
            sw_state_d    = SW_IDLE;
          end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
          end
        end else if (swt_s != swt_q) begin
          sw_cand_d = swt_s;
          sw_cnt_d  = '0;
        end else begin
          sw_state_d = SW_IDLE;
        end
      end
    endcase
  end

  logic [1:0]    res_state_q, res_state_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;
  logic          resume_held_q, resume_held_d;
  logic          resume_pulse_q, resume_pulse_d;

  always_comb begin
    res_state_d    = res_state_q;
    res_cnt_d      = res_cnt_q;
    resume_held_d  = resume_held_q;
    resume_pulse_d = 1'b0;
    case (res_state_q)
      RES_IDLE: begin
        if (res_s) begin
          res_cnt_d   = '0;
          res_state_d = RES_PRESS_CHK;
        end
      end
      RES_PRESS_CHK: begin
        if (!res_s) begin
          res_state_d = RES_IDLE;
        end else if (res_cnt_q == CNT_LAST) begin
          res_state_d    = RES_PRESSED;
          resume_held_d  = 1'b1;
          resume_pulse_d = 1'b1;
        end else begin
          res_cnt_d = res_cnt_q + CNT_ONE;
        end
      end
      RES_PRESSED: begin
        if (!res_s) begin
          res_cnt_d   = '0;
          res_state_d = RES_RELEASE_CHK;
        end
      end
      default: begin
        // A bounce during release returns to PRESSED without re-pulsing.
        if (res_s) begin
          res_state_d = RES_PRESSED;
        end else if (res_cnt_q == CNT_LAST) begin
          res_state_d   = RES_IDLE;
          resume_held_d = 1'b0;
        end else begin
          res_cnt_d = res_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_state_q     <= SW_IDLE;
      sw_cand_q      <= '0;
      sw_cnt_q       <= '0;
      swt_q          <= '0;
      swt_changed_q  <= 1'b0;
      res_state_q    <= RES_IDLE;
      res_cnt_q      <= '0;
      resume_held_q  <= 1'b0;
      resume_pulse_q <= 1'b0;
    end else begin
      sw_state_q     <= sw_state_d;
      sw_cand_q      <= sw_cand_d;
      sw_cnt_q       <= sw_cnt_d;
      swt_q          <= swt_d;
      swt_changed_q  <= swt_changed_d;
      res_state_q    <= res_state_d;
      res_cnt_q      <= res_cnt_d;
      resume_held_q  <= resume_held_d;
      resume_pulse_q <= resume_pulse_d;
    end
  end

  assign swt          = swt_q;
  assign swt_changed  = swt_changed_q;
  assign resume_held  = resume_held_q;
  assign resume_pulse = resume_pulse_q;

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed bench for aux_input_conditioner with SyncStages=2, DebounceCnt=4 (latency 7 edges).
module tb_aux_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] swt_raw;
  logic        resume_raw;
  logic [15:0] swt;
  logic        swt_changed;
  logic        resume_held;
  logic        resume_pulse;

  int checks   = 0;
  int failures = 0;

  aux_input_conditioner #(.SwtWidth(16), .SyncStages(2), .DebounceCnt(4)) dut (
    .clk(clk), .rst(rst), .swt_raw(swt_raw), .resume_raw(resume_raw),
    .swt(swt), .swt_changed(swt_changed), .resume_held(resume_held),
    .resume_pulse(resume_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] swt_raw;
    logic        res_raw;
    logic [15:0] e_swt;
    logic        e_chg;
    logic        e_held;
    logic        e_pulse;
  } vec_t;

  vec_t tbl [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] obs();
    return {swt, swt_changed, resume_held, resume_pulse};
  endfunction

  task automatic chk(input string name, input int idx, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got swt=%h chg=%b held=%b pulse=%b exp swt=%h chg=%b held=%b pulse=%b",
               name, idx, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    swt_raw = 16'hA5A5;
    resume_raw = 1'b0;

    // Reset for 3 edges, release, A5A5 accepted on edge 7; then a 3-cycle button blip.
    for (int i = 0; i < 22; i++) begin
      tbl[i].rst     = (i < 3);
      tbl[i].swt_raw = 16'hA5A5;
      tbl[i].res_raw = (i >= 11 && i <= 13);
      tbl[i].e_swt   = (i >= 9) ? 16'hA5A5 : 16'h0000;
      tbl[i].e_chg   = (i == 9);
      tbl[i].e_held  = 1'b0;
      tbl[i].e_pulse = 1'b0;
    end
    for (int i = 0; i < 22; i++) begin
      rst        = tbl[i].rst;
      swt_raw    = tbl[i].swt_raw;
      resume_raw = tbl[i].res_raw;
      step();
      chk("table", i, obs(), {tbl[i].e_swt, tbl[i].e_chg, tbl[i].e_held, tbl[i].e_pulse});
    end

    // Long press: pulse on edge 7, held until 7 edges after the fall (input falls for edge 21).
    for (int k = 1; k <= 30; k++) begin
      resume_raw = (k <= 20);
      step();
      chk("long_press", k, obs(), {16'hA5A5, 1'b0, (k >= 7 && k <= 26), (k == 7)});
    end

    // Bouncy press: four 2-high/2-low pairs then steady high from edge 17.
    for (int k = 1; k <= 26; k++) begin
      resume_raw = (k <= 16) ? (((k - 1) % 4) < 2) : 1'b1;
      step();
      chk("bounce", k, obs(), {16'hA5A5, 1'b0, (k >= 23), (k == 23)});
    end

    // Reset while button held: everything clears, then switch and button both re-accept on edge 7.
    rst = 1'b1;
    step();
    chk("rst_held", 0, obs(), 19'd0);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("rst_held", k, obs(), {(k >= 7) ? 16'hA5A5 : 16'h0000, (k == 7), (k >= 7), (k == 7)});
    end

    // Release the button and move the switches to 0.
    resume_raw = 1'b0;
    swt_raw = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("release", k, obs(), {(k >= 7) ? 16'h0000 : 16'hA5A5, (k == 7), (k < 7), 1'b0});
    end

    // Candidate restart: 0001 for 2 cycles then 0003 gives one strobe straight to 0003.
    for (int k = 1; k <= 11; k++) begin
      swt_raw = (k <= 2) ? 16'h0001 : 16'h0003;
      step();
      chk("restart", k, obs(), {(k >= 9) ? 16'h0003 : 16'h0000, (k == 9), 1'b0, 1'b0});
    end

    // Short glitch to 0007 returns to 0003: no strobe, no change.
    for (int k = 1; k <= 10; k++) begin
      swt_raw = (k <= 2) ? 16'h0007 : 16'h0003;
      step();
      chk("glitch", k, obs(), {16'h0003, 1'b0, 1'b0, 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
